if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Decoupling buffer between the fetch stage and the decode stage.
//  Captures {pc, instr} pairs produced by fetch and presents them in order
//  to decode, with a valid/ready handshake on both sides.
//  Absorbs decode stalls without dropping fetched instructions.
//  A flush discards all wrong-path contents after a taken branch or jump
//  resolved in EX/MEM.
// PARAMETERS
//  DEPTH   2   number of {pc,instr} entries held; power of two, >= 2
//  NOP     32'h00000013   instruction word presented when the queue is empty
// PORTS
//  clk          in   1    single clock; all state updates on rising edge
//  rst          in   1    asynchronous, active-low reset
//  flush_i      in   1    drop all entries and any same-cycle enqueue
//  if_valid_i   in   1    fetch presents a valid {pc,instr} this cycle
//  if_pc_i      in   32   pc of the fetched instruction
//  if_instr_i   in   32   fetched instruction word
//  if_ready_o   out  1    queue accepts an enqueue this cycle
//  id_valid_o   out  1    head entry is valid for decode
//  id_pc_o      out  32   pc of head entry
//  id_instr_o   out  32   instruction of head entry; NOP when empty
//  id_ready_i   in   1    decode consumes the head entry this cycle
//  count_o      out  $clog2(DEPTH+1)  number of occupied entries
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - head/tail pointers = 0, count_o = 0
//   - id_valid_o = 0, id_pc_o = 0, id_instr_o = NOP, if_ready_o = 1
//   - Storage contents are don't-care.
//   - Reset asserted mid-operation empties the queue immediately, with no
//     wait for a clock edge.
//  Handshakes:
//   - Enqueue fires when if_valid_i & if_ready_o & !flush_i.
//   - Dequeue fires when id_valid_o & id_ready_i & !flush_i.
//  if_ready_o:
//   - Equals (count_o != DEPTH).
//   - It is registered-state only, with no combinational path from id_ready_i.
//   - Consequently, when full, an enqueue is refused even if a dequeue
//     fires in the same cycle.
//  Outputs:
//   - id_valid_o = (count_o != 0).
//   - id_pc_o / id_instr_o are driven from the head entry.
//   - When empty: id_pc_o = 0 and id_instr_o = NOP.
//   - No same-cycle bypass: an entry enqueued at edge N is visible to
//     decode after edge N (latency 1 cycle).
//  Count update per edge:
//   - +1 on enqueue only; -1 on dequeue only.
//   - Unchanged when both fire or when neither fires.
//   - Pointers advance modulo DEPTH and wrap from DEPTH-1 to 0.
//   - Order is strictly FIFO across wrap.
//  Flush:
//   - Next edge: count = 0, head = tail = 0.
//   - An enqueue and a dequeue presented in the same cycle are both ignored.
//   - if_ready_o is 1 in the cycle after a flush.
//   - Flush takes priority over all other events.
//  Illegal inputs:
//   - if_valid_i while !if_ready_o is ignored; fetch must hold its pc.
//   - id_ready_i while empty is a no-op.
//  Data is stored unmodified; there is no width conversion or arithmetic
//  beyond pointer/count increment.
// TESTING
//  1. Reset: rst=0 mid-stream with 2 entries held -> the same cycle gives
//     id_valid_o=0, count_o=0, id_instr_o=32'h00000013, if_ready_o=1.
//  2. Single pass: enqueue pc=0x60, instr=0x00500093 with id_ready_i=1 ->
//     the next cycle gives id_valid_o=1, id_pc_o=0x60; the cycle after
//     gives empty.
//  3. Backpressure: id_ready_i=0, enqueue 0x60,0x64,0x68 ->
//     - 0x60 and 0x64 are accepted; count_o=2, if_ready_o=0.
//     - 0x68 is refused.
//     - With id_ready_i=1, decode sees 0x60 then 0x64.
//  4. Simultaneous enqueue/dequeue at count=1 over 8 cycles ->
//     - count_o stays 1.
//     - Pointers wrap past DEPTH-1.
//     - pcs emerge in issue order 0x60..0x7C.
//  5. Flush with queue full, plus an enqueue of 0x200 and id_ready_i=1 in
//     the same cycle ->
//     - Next cycle: count_o=0, id_valid_o=0, nothing dequeued.
//     - The next enqueue of 0x200 appears at head.
//  6. Full-plus-dequeue: count=2, id_ready_i=1, if_valid_i=1 ->
//     count_o becomes 1 and the new entry is not written.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
// The queue takes the slave modport; fetch, decode and branch-flush logic drive the master side.
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          flush_i;
  logic          if_valid_i;
  logic [31:0]   if_pc_i;
  logic [31:0]   if_instr_i;
  logic          if_ready_o;
  logic          id_valid_o;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_instr_o;
  logic          id_ready_i;
  logic [CW-1:0] count_o;

  modport master (
    output flush_i, if_valid_i, if_pc_i, if_instr_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
  );

  modport slave (
    input  flush_i, if_valid_i, if_pc_i, if_instr_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: holds {pc, instr} pairs from fetch and hands them to decode in order.
// A flush empties the queue; outputs reflect registered state only (no enqueue bypass).
module if_id_queue #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          enq;
  logic          deq;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Readiness is taken from count alone, so a full queue refuses fetch even when decode drains.
  always_comb begin
    enq = q.if_valid_i & ~full & ~q.flush_i;
    deq = ~empty & q.id_ready_i & ~q.flush_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]    <= q.if_pc_i;
      instr_mem[tail] <= q.if_instr_i;
    end
  end

  assign q.if_ready_o = ~full;
  assign q.id_valid_o = ~empty;
  assign q.id_pc_o    = empty ? '0  : pc_mem[head];
  assign q.id_instr_o = empty ? NOP : instr_mem[head];
  assign q.count_o    = count;
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by random fetch/decode/flush traffic.
module tb_if_id_queue;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_queue_if #(.DEPTH(DEPTH)) qif ();

  if_id_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int     exp_cnt  = 0;
  int     nxt_cnt  = 0;
  int     checks   = 0;
  int     failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  // One clock cycle of stimulus; the reference FIFO and occupancy follow the handshake rules.
  task automatic cycle(input bit fl, input bit v, input logic [31:0] pc,
                       input logic [31:0] instr, input bit rdy);
    bit enq;
    bit deq;
    @(posedge clk);
    #1;
    exp_cnt        = nxt_cnt;
    qif.flush_i    = fl;
    qif.if_valid_i = v;
    qif.if_pc_i    = pc;
    qif.if_instr_i = instr;
    qif.id_ready_i = rdy;
    enq = v && (exp_cnt != int'(DEPTH)) && !fl;
    deq = (exp_cnt != 0) && rdy && !fl;
    if (enq) exp_q.push_back({pc, instr});
    nxt_cnt = fl ? 0 : exp_cnt + int'(enq) - int'(deq);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #1;
    qif.flush_i    = 1'b0;
    qif.if_valid_i = 1'b0;
    qif.id_ready_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_count",    32'(qif.count_o), 32'd0);
    chk("rst_id_valid", 32'(qif.id_valid_o), 32'd0);
    chk("rst_id_pc",    qif.id_pc_o, 32'd0);
    chk("rst_id_instr", qif.id_instr_o, NOP);
    chk("rst_if_ready", 32'(qif.if_ready_o), 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    nxt_cnt = 0;
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares state every cycle and pops the scoreboard on each observed dequeue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("count",    32'(qif.count_o), 32'(exp_cnt));
        chk("id_valid", 32'(qif.id_valid_o), 32'(exp_cnt != 0));
        chk("if_ready", 32'(qif.if_ready_o), 32'(exp_cnt != int'(DEPTH)));
        if (exp_cnt == 0) begin
          chk("empty_pc",    qif.id_pc_o, 32'd0);
          chk("empty_instr", qif.id_instr_o, NOP);
        end
        if (qif.id_valid_o && qif.id_ready_i && !qif.flush_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL deq_unexpected: actual pc=%h required=no entry", qif.id_pc_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("deq_pc",    qif.id_pc_o, mon_e.pc);
            chk("deq_instr", qif.id_instr_o, mon_e.instr);
          end
        end else if (exp_cnt != 0 && exp_q.size() != 0) begin
          chk("head_pc", qif.id_pc_o, exp_q[0].pc);
        end
        if (qif.flush_i) exp_q.delete();
      end
    end
  end

  initial begin
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    bit          fl;
    bit          v;
    bit          rdy;

    qif.flush_i    = 1'b0;
    qif.if_valid_i = 1'b0;
    qif.if_pc_i    = '0;
    qif.if_instr_i = '0;
    qif.id_ready_i = 1'b0;
    #2;
    chk("init_count",    32'(qif.count_o), 32'd0);
    chk("init_id_valid", 32'(qif.id_valid_o), 32'd0);
    chk("init_id_instr", qif.id_instr_o, NOP);
    chk("init_if_ready", 32'(qif.if_ready_o), 32'd1);
    #1;
    rst = 1'b1;

    // Single pass
    cycle(0, 1, 32'h60, 32'h0050_0093, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);

    // Backpressure: third enqueue refused while full
    cycle(0, 1, 32'h60, 32'h1111_0001, 0);
    cycle(0, 1, 32'h64, 32'h1111_0002, 0);
    cycle(0, 1, 32'h68, 32'h1111_0003, 0);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);

    // Steady enqueue+dequeue at count 1, wrapping pointers
    cycle(0, 1, 32'h60, 32'h2222_0000, 0);
    for (int i = 1; i <= 8; i++)
      cycle(0, 1, 32'h60 + 32'(4 * i), 32'h2222_0000 + 32'(i), 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0);

    // Flush while full with same-cycle enqueue and dequeue
    cycle(0, 1, 32'h100, 32'h3333_0001, 0);
    cycle(0, 1, 32'h104, 32'h3333_0002, 0);
    cycle(1, 1, 32'h200, 32'h3333_0200, 1);
    cycle(0, 1, 32'h200, 32'h3333_0200, 0);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0);

    // Full plus dequeue: enqueue refused, count drops to 1
    cycle(0, 1, 32'h300, 32'h4444_0001, 0);
    cycle(0, 1, 32'h304, 32'h4444_0002, 0);
    cycle(0, 1, 32'h308, 32'h4444_0003, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0);

    // Asynchronous reset with two entries held
    cycle(0, 1, 32'h400, 32'h5555_0001, 0);
    cycle(0, 1, 32'h404, 32'h5555_0002, 0);
    cycle(0, 0, 32'h0, 32'h0, 0);
    reset_mid_cycle();
    cycle(0, 0, 32'h0, 32'h0, 1);

    // Random traffic; fetch holds pc/instr until accepted
    pc_r    = 32'h1000;
    instr_r = $urandom;
    for (int n = 0; n < 400; n++) begin
      fl  = ($urandom_range(15) == 0);
      v   = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      cycle(fl, v, pc_r, instr_r, rdy);
      if (v && !fl && exp_cnt != int'(DEPTH)) begin
        pc_r    = pc_r + 32'd4;
        instr_r = $urandom;
      end
    end

    for (int n = 0; n < 4; n++) cycle(0, 0, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
